uart_rx_gen: RTL

Parametrised UART receiver for the S.Bus input path. It is the successor to the fixed 8E2 receiver and is configurable in data width, parity mode, stop-bit count and line polarity. It adds majority-vote sampling, start-bit glitch rejection, break detection and inter-frame gap detection. Received frames pass through an internal show-ahead FIFO with a valid/ready handshake, so the downstream channel decoder can stall without losing bytes.

---
 rtl/uart_rx_gen_if.sv | 13 +
 rtl/uart_rx_gen.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_gen_if.sv
// Receive-side handshake bundle: head-of-FIFO entry plus valid/ready.
interface uart_rx_gen_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 rx_valid;
  logic                 rx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_pe;
  logic                 rx_fe;

  modport master (output rx_valid, rx_data, rx_pe, rx_fe, input rx_ready);
  modport slave  (input rx_valid, rx_data, rx_pe, rx_fe, output rx_ready);
endinterface

// File: rtl/uart_rx_gen.sv
// Parametrised UART receiver: majority-vote sampling, glitch/break/gap detection,
// and a show-ahead FIFO towards the consumer.
module uart_rx_gen #(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned BIT_RATE    = 100_000,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY_MODE = 1,
  parameter int unsigned STOP_BITS   = 2,
  parameter int unsigned INVERT      = 0,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned GAP_BITS    = 20
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           uart_rxd,
  input  logic           rx_en,
  uart_rx_gen_if.master  rx,
  output logic           rx_overflow,
  output logic           rx_break,
  output logic           rx_gap
);

  localparam int unsigned CPB       = CLK_HZ / BIT_RATE;
  localparam int unsigned CW        = $clog2(CPB);
  localparam logic [CW-1:0] T_A     = CW'(CPB/2 - 1);
  localparam logic [CW-1:0] T_B     = CW'(CPB/2);
  localparam logic [CW-1:0] T_C     = CW'(CPB/2 + 1);
  localparam logic [CW-1:0] T_END   = CW'(CPB - 1);
  localparam int unsigned AW        = $clog2(FIFO_DEPTH);
  localparam int unsigned EW        = DATA_BITS + 2;
  localparam int unsigned GAP_TICKS = GAP_BITS * CPB;
  localparam int unsigned GW        = $clog2(GAP_TICKS);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TICKS - 1);
  localparam logic [3:0]  LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic        LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;

  state_t               state, state_n;
  logic                 rx_in, sync1, rxs;
  logic [CW-1:0]        cnt;
  logic [3:0]           bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 pe_r, fe_r, par_bit;
  logic                 samp_a, samp_b, vote, vote_tick, bit_end, exp_par;
  logic                 push, brk_evt, brk_exit, start_evt;
  logic [EW-1:0]        entry, head;
  logic [EW-1:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count;
  logic                 full, pop, do_push, ovf;
  logic                 armed;
  logic [GW-1:0]        idle_cnt;

  assign rx_in = (INVERT != 0) ? ~uart_rxd : uart_rxd;

  // Synchroniser powers up at the idle level so reset cannot fake a start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rx_in;
      rxs   <= sync1;
    end
  end

  assign vote      = (samp_a & samp_b) | (samp_a & rxs) | (samp_b & rxs);
  assign vote_tick = (cnt == T_C);
  assign bit_end   = (cnt == T_END);
  assign exp_par   = (PARITY_MODE == 2) ? ~^shreg : ^shreg;
  assign entry     = {fe_r | ~vote, pe_r, shreg};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    push     = 1'b0;
    brk_evt  = 1'b0;
    brk_exit = 1'b0;
    case (state)
      IDLE:   if (rx_en && !rxs) state_n = START;
      START: begin
        if (vote_tick && vote) state_n = IDLE;
        else if (bit_end)      state_n = DATA;
      end
      DATA:   if (bit_end && bit_idx == LAST_BIT) state_n = (PARITY_MODE != 0) ? PARITY : STOP;
      PARITY: if (bit_end) state_n = STOP;
      STOP: begin
        if (vote_tick) begin
          // An all-zero frame through the first stop bit is a line break, not data.
          if (!stop_idx && shreg == '0 && !par_bit && !vote) begin
            state_n = BRK;
            brk_evt = 1'b1;
          end else if (stop_idx == LAST_STOP) begin
            state_n = IDLE;
            push    = 1'b1;
          end
        end
      end
      BRK: if (rxs) begin
        state_n  = IDLE;
        brk_exit = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    if (!rx_en) begin
      state_n  = IDLE;
      push     = 1'b0;
      brk_evt  = 1'b0;
      brk_exit = 1'b0;
    end
  end

  assign start_evt = (state == IDLE) && (state_n == START);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      pe_r     <= 1'b0;
      fe_r     <= 1'b0;
      par_bit  <= 1'b0;
      samp_a   <= 1'b1;
      samp_b   <= 1'b1;
    end else begin
      if (state_n != state || bit_end || state_n == IDLE || state_n == BRK) cnt <= '0;
      else cnt <= cnt + 1'b1;
      if (cnt == T_A) samp_a <= rxs;
      if (cnt == T_B) samp_b <= rxs;
      case (state)
        START: begin
          bit_idx  <= '0;
          stop_idx <= 1'b0;
          pe_r     <= 1'b0;
          fe_r     <= 1'b0;
          par_bit  <= 1'b0;
        end
        DATA: begin
          if (vote_tick) shreg <= {vote, shreg[DATA_BITS-1:1]};
          if (bit_end)   bit_idx <= bit_idx + 1'b1;
        end
        PARITY: if (vote_tick) begin
          par_bit <= vote;
          pe_r    <= (vote != exp_par);
        end
        STOP: begin
          if (vote_tick) fe_r <= fe_r | ~vote;
          if (bit_end)   stop_idx <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign pop     = rx.rx_valid && rx.rx_ready;
  assign do_push = push && (!full || pop);
  assign ovf     = push && full && !pop;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !pop)      count <= count + 1'b1;
      else if (!do_push && pop) count <= count - 1'b1;
    end
  end

  assign head        = mem[rd_ptr];
  assign rx.rx_valid = (count != '0);
  assign rx.rx_data  = rx.rx_valid ? head[DATA_BITS-1:0] : '0;
  assign rx.rx_pe    = rx.rx_valid & head[DATA_BITS];
  assign rx.rx_fe    = rx.rx_valid & head[DATA_BITS+1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_overflow <= 1'b0;
      rx_break    <= 1'b0;
      rx_gap      <= 1'b0;
      armed       <= 1'b0;
      idle_cnt    <= '0;
    end else begin
      rx_overflow <= ovf;
      rx_break    <= brk_evt;
      rx_gap      <= 1'b0;
      if (do_push || brk_exit) begin
        armed    <= 1'b1;
        idle_cnt <= '0;
      end else if (start_evt) begin
        idle_cnt <= '0;
      end else if (armed && rx_en && state == IDLE && rxs) begin
        if (idle_cnt == GAP_LAST) begin
          rx_gap <= 1'b1;
          armed  <= 1'b0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end
    end
  end

endmodule
